// File: rtl/add_seq_pkg.sv
// Shared constants and FSM encoding for the slice-serial adder/subtractor.
package add_seq_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_16_bit.sv
// 16-bit ripple-carry adder; purely combinational, no handshake.
module full_adder_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);

    logic [16:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[16];

endmodule

// File: rtl/add_seq_64.sv
// Slice-serial W-bit add/sub through one 16-bit adder; done NSLICE+1 cycles after start.
// No backpressure: start is only sampled in IDLE/DONE and ignored while busy.
module add_seq_64
    import add_seq_pkg::*;
#(
    parameter int NSLICE = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sub,
    input  logic [SLICE_W*NSLICE-1:0] a,
    input  logic [SLICE_W*NSLICE-1:0] b,
    output logic                      busy,
    output logic                      done,
    output logic [SLICE_W*NSLICE-1:0] s,
    output logic                      cout,
    output logic                      ovf
);

    localparam int W    = SLICE_W * NSLICE;
    localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_t            r_state;
    state_t            w_nxt;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_sub;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_s;
    logic              r_cout;
    logic              r_ovf;

    logic              w_accept;
    logic              w_last;
    logic [SLICE_W-1:0] w_a_sl;
    logic [SLICE_W-1:0] w_bx_sl;
    logic              w_cin;
    logic [SLICE_W-1:0] w_sum;
    logic              w_cout;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_idx == LAST_IDX);

    // Subtraction is a + ~b + 1: invert b and inject the +1 as slice 0's carry-in.
    assign w_a_sl  = r_a[SLICE_W*r_idx +: SLICE_W];
    assign w_bx_sl = r_b[SLICE_W*r_idx +: SLICE_W] ^ {SLICE_W{r_sub}};
    assign w_cin   = (r_idx == '0) ? r_sub : r_carry;

    full_adder_16_bit u_slice_add (
        .a    (w_a_sl),
        .b    (w_bx_sl),
        .cin  (w_cin),
        .s    (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_nxt = RUN;
            RUN:     if (w_last) w_nxt = DONE;
            DONE:    w_nxt = start ? RUN : IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_idx <= '0;
            r_a   <= a;
            r_b   <= b;
            r_sub <= sub;
        end else if (r_state == RUN) begin
            r_s[SLICE_W*r_idx +: SLICE_W] <= w_sum;
            r_carry <= w_cout;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_cout;
                r_ovf  <= (w_a_sl[SLICE_W-1] == w_bx_sl[SLICE_W-1]) &&
                          (w_sum[SLICE_W-1] != w_a_sl[SLICE_W-1]);
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_add_seq_64.sv
// Scoreboard bench for add_seq_64: reference results queued at start, compared at done.
module tb_add_seq_64;

    typedef struct packed {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] s;
    logic        cout;
    logic        ovf;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    add_seq_64 #(.NSLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb, input logic msub);
        exp_t        e;
        logic [63:0] bx;
        logic [64:0] sum;
        bx     = msub ? ~mb : mb;
        sum    = {1'b0, ma} + {1'b0, bx} + 65'(msub);
        e.s    = sum[63:0];
        e.cout = sum[64];
        e.ovf  = (ma[63] == bx[63]) && (sum[63] != ma[63]);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns one cycle later (cycle N+1).
    task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic isub);
        start = 1'b1;
        a     = ia;
        b     = ib;
        sub   = isub;
        sb_q.push_back(model(ia, ib, isub));
        step();
        start = 1'b0;
    endtask

    // Waits (bounded) for done; cyc is the cycle offset from the start cycle.
    task automatic wait_done(input int c0, output int cyc, output int busy_cnt, output bit seen);
        cyc      = c0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        step();
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (s !== 64'd0) begin n_err++; $display("FAIL reset_s got %h want 0", s); end
        n_vec++; if ({cout, ovf} !== 2'b00) begin n_err++; $display("FAIL reset_cout_ovf got %b want 00", {cout, ovf}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_sub();
        logic [63:0] va[8];
        logic [63:0] vb[8];
        logic        vs[8];
        int          cyc, bc;
        bit          seen;
        exp_t        e;
        va[0] = 64'h0000_0000_FFFF_FFFF; vb[0] = 64'd1;                 vs[0] = 1'b0;
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'hFFFF_FFFF_FFFF_FFFF; vs[1] = 1'b0;
        va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'd1;                 vs[2] = 1'b0;
        va[3] = 64'd0;                   vb[3] = 64'd1;                 vs[3] = 1'b1;
        va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'd1;                 vs[4] = 1'b1;
        for (int i = 5; i < 8; i++) begin
            va[i] = {$urandom(), $urandom()};
            vb[i] = {$urandom(), $urandom()};
            vs[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            issue(va[i], vb[i], vs[i]);
            wait_done(1, cyc, bc, seen);
            n_vec++;
            if (!seen || cyc != 5 || bc != 4) begin
                n_err++;
                $display("FAIL add_latency[%0d] got done=%b cyc=%0d busy_cycles=%0d want cyc=5 busy_cycles=4", i, seen, cyc, bc);
            end
            e = sb_q.pop_front();
            n_vec++;
            if ({s, cout, ovf} !== {e.s, e.cout, e.ovf}) begin
                n_err++;
                $display("FAIL add_result[%0d] got s=%h c=%b v=%b want s=%h c=%b v=%b", i, s, cout, ovf, e.s, e.cout, e.ovf);
            end
            step();
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || s !== e.s || cout !== e.cout || ovf !== e.ovf) begin
                n_err++;
                $display("FAIL idle_hold[%0d] got done=%b busy=%b s=%h want done=0 busy=0 s=%h", i, done, busy, s, e.s);
            end
        end
        // Fixed-value spot checks from the known vectors.
        n_vec++;
        if (model(va[2], vb[2], 1'b0) !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL model_ovf_vector mismatch in reference");
        end
    endtask

    task automatic test_back_to_back();
        int   cyc, bc;
        bit   seen;
        exp_t e;
        issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        start = 1'b1;
        a     = 64'hFFFF_0000_FFFF_0000;
        b     = 64'h0001_0001_0001_0001;
        sub   = 1'b1;
        sb_q.push_back(model(a, b, sub));
        wait_done(1, cyc, bc, seen);
        e = sb_q.pop_front();
        n_vec++;
        if (!seen || cyc != 5 || busy !== 1'b0 || {s, cout, ovf} !== {e.s, e.cout, e.ovf}) begin
            n_err++;
            $display("FAIL b2b_first got done=%b cyc=%0d busy=%b s=%h want cyc=5 busy=0 s=%h", seen, cyc, busy, s, e.s);
        end
        step();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL b2b_no_bubble got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        wait_done(1, cyc, bc, seen);
        e = sb_q.pop_front();
        n_vec++;
        if (!seen || cyc != 5 || bc != 4 || {s, cout, ovf} !== {e.s, e.cout, e.ovf}) begin
            n_err++;
            $display("FAIL b2b_second got done=%b cyc=%0d busy_cycles=%0d s=%h want cyc=5 busy_cycles=4 s=%h", seen, cyc, bc, s, e.s);
        end
        step();
    endtask

    task automatic test_start_in_run();
        int   cyc, bc;
        bit   seen;
        exp_t e;
        issue(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);
        step();
        start = 1'b1;
        a     = 64'hDEAD_BEEF_DEAD_BEEF;
        b     = 64'h1111_1111_1111_1111;
        sub   = 1'b1;
        step();
        start = 1'b0;
        wait_done(3, cyc, bc, seen);
        e = sb_q.pop_front();
        n_vec++;
        if (!seen || cyc != 5 || {s, cout, ovf} !== {e.s, e.cout, e.ovf}) begin
            n_err++;
            $display("FAIL run_start_ignored got done=%b cyc=%0d s=%h want cyc=5 s=%h", seen, cyc, s, e.s);
        end
        step();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL run_start_no_rerun got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int   cyc, bc;
        bit   seen;
        bit   saw_done;
        exp_t e;
        issue(64'h0003_0002_FFFF_FFFF, 64'h0001_0001_0001_0001, 1'b0);
        e = sb_q.pop_back();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 64'd0 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got busy=%b done=%b s=%h c=%b v=%b want all 0", busy, done, s, cout, ovf);
        end
        step();
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_no_done got done_seen=%b busy=%b want 0 0", saw_done, busy);
        end
        issue(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b1);
        wait_done(1, cyc, bc, seen);
        e = sb_q.pop_front();
        n_vec++;
        if (!seen || cyc != 5 || {s, cout, ovf} !== {e.s, e.cout, e.ovf}) begin
            n_err++;
            $display("FAIL post_reset_op got done=%b cyc=%0d s=%h c=%b v=%b want s=%h c=%b v=%b", seen, cyc, s, cout, ovf, e.s, e.cout, e.ovf);
        end
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_start_in_run();
        test_reset_mid_run();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
